// File: rtl/inst_pkg.sv
// inst_pkg - shared instruction field layout for the encoder and decode paths
// Purpose: instruction type enum and the LSB/width of every field in the
//          32-bit instruction word.
package inst_pkg;

    typedef enum logic [1:0] {
        IT_R1 = 2'b00,
        IT_R2 = 2'b01,
        IT_RI = 2'b10,
        IT_BR = 2'b11
    } inst_type_e;

    localparam int TYPE_LSB = 0;
    localparam int TYPE_W   = 2;
    localparam int OPC_LSB  = 2;
    localparam int OPC_W    = 4;
    localparam int SRC1_LSB = 6;
    localparam int SRC1_W   = 5;
    localparam int SRC2_LSB = 11;
    localparam int SRC2_W   = 5;
    // COND shares bit positions with SRC2; they are never encoded together.
    localparam int COND_LSB = 11;
    localparam int COND_W   = 5;
    // On RI words DEST overlays the low IMM bits, so only imm[15:5] survives.
    localparam int DEST_LSB = 16;
    localparam int DEST_W   = 5;
    localparam int IMM_LSB  = 16;
    localparam int IMM_W    = 16;

endpackage

// File: rtl/inst_fifo.sv
// rtl/inst_fifo.sv - valid/ready FIFO holding encoded words with their error flag
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   i_valid/o_ready    write side handshake, i_data written on i_valid && o_ready
//   o_valid/i_ready    read side handshake, o_data is the head entry
module inst_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the low bits match.
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty = (r_wptr == r_rptr);

    // No full-bypass: a pop in the same cycle does not open the input side.
    assign o_ready = !w_full;
    assign o_valid = !w_empty;
    assign w_push  = i_valid && !w_full;
    assign w_pop   = i_ready && !w_empty;

    // Storage is not reset; the empty gate keeps stale entries off the output.
    assign o_data  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - packs instruction fields into 32-bit words with a field-error flag
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid/in_ready           field bundle handshake
//   in_type..in_imm             instruction fields
//   out_valid/out_ready         encoded word handshake
//   out_inst, out_err           FIFO head word and its error flag
//   inst_cnt, err_cnt           popped words / popped error words, wrapping
module inst_encoder
    import inst_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16,
    parameter int STRICT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_type,
    input  logic [3:0]       in_opcode,
    input  logic [4:0]       in_src1,
    input  logic [4:0]       in_src2,
    input  logic [4:0]       in_dest,
    input  logic [4:0]       in_cond,
    input  logic [15:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] inst_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    inst_type_e  w_type;
    logic [31:0] w_inst;
    logic        w_clash;
    logic        w_unused_nz;
    logic        w_err;
    logic        w_pop;

    logic [CNT_W-1:0] r_inst_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    assign w_type = inst_type_e'(in_type);

    always_comb begin
        w_inst = '0;
        w_inst[TYPE_LSB +: TYPE_W] = in_type;
        w_inst[OPC_LSB  +: OPC_W]  = in_opcode;
        w_inst[SRC1_LSB +: SRC1_W] = in_src1;
        case (w_type)
            IT_R2: w_inst[SRC2_LSB +: SRC2_W] = in_src2;
            IT_RI: begin
                // Write imm first so dest overwrites its low bits.
                w_inst[IMM_LSB  +: IMM_W]  = in_imm;
                w_inst[DEST_LSB +: DEST_W] = in_dest;
            end
            IT_BR: begin
                w_inst[COND_LSB +: COND_W] = in_cond;
                w_inst[IMM_LSB  +: IMM_W]  = in_imm;
            end
            default: ;
        endcase
    end

    assign w_clash = (w_type == IT_RI) && (in_imm[DEST_W-1:0] != in_dest);

    assign w_unused_nz = ((in_src2 != '0) && (w_type != IT_R2))
                      || ((in_dest != '0) && (w_type != IT_RI))
                      || ((in_cond != '0) && (w_type != IT_BR))
                      || ((in_imm  != '0) && ((w_type == IT_R1) || (w_type == IT_R2)));

    assign w_err = w_clash || ((STRICT != 0) && w_unused_nz);

    inst_fifo #(
        .WIDTH (33),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  ({w_err, w_inst}),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  ({out_err, out_inst})
    );

    assign w_pop = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst_cnt <= '0;
            r_err_cnt  <= '0;
        end else if (w_pop) begin
            r_inst_cnt <= r_inst_cnt + 1'b1;
            if (out_err) r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign inst_cnt = r_inst_cnt;
    assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - self-checking bench for inst_encoder
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  ty = '0;
    logic [3:0]  op = '0;
    logic [4:0]  s1 = '0, s2 = '0, d = '0, c = '0;
    logic [15:0] im = '0;

    logic        in_ready, out_valid, out_err;
    logic [31:0] out_inst;
    logic [15:0] inst_cnt, err_cnt;
    logic        in_ready2, out_valid2, out_err2;
    logic [31:0] out_inst2;
    logic [3:0]  inst_cnt2, err_cnt2;

    int n_pass = 0;
    int n_total = 0;
    logic [32:0] q_s[$];
    logic [32:0] q_n[$];
    int n_pop = 0, n_err_s = 0, n_err_n = 0;

    always #5 clk = ~clk;

    inst_encoder #(.DEPTH(4), .CNT_W(16), .STRICT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_type(ty), .in_opcode(op), .in_src1(s1), .in_src2(s2),
        .in_dest(d), .in_cond(c), .in_imm(im),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_err(out_err), .inst_cnt(inst_cnt), .err_cnt(err_cnt)
    );

    inst_encoder #(.DEPTH(4), .CNT_W(4), .STRICT(0)) dut_loose (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_type(ty), .in_opcode(op), .in_src1(s1), .in_src2(s2),
        .in_dest(d), .in_cond(c), .in_imm(im),
        .out_valid(out_valid2), .out_ready(out_ready), .out_inst(out_inst2),
        .out_err(out_err2), .inst_cnt(inst_cnt2), .err_cnt(err_cnt2)
    );

    function automatic logic [31:0] model_word(input int unsigned t, o, a, b, de, co, i);
        int unsigned w;
        w = t + o * 4 + a * 64;
        if (t == 1) w += b * 2048;
        if (t == 2) w += (i / 32) * 2097152 + de * 65536;
        if (t == 3) w += co * 2048 + i * 65536;
        return w;
    endfunction

    function automatic logic model_err(input int strict, input int unsigned t, b, de, co, i);
        logic clash, loose;
        clash = (t == 2) && ((i % 32) != de);
        loose = (b != 0 && t != 1) || (de != 0 && t != 2) || (co != 0 && t != 3)
             || (i != 0 && t <= 1);
        return clash || (strict != 0 && loose);
    endfunction

    task automatic rand_fields();
        ty = 2'($urandom_range(0, 3));
        op = 4'($urandom);
        s1 = 5'($urandom);
        s2 = $urandom_range(0, 1) ? 5'($urandom) : 5'd0;
        d  = $urandom_range(0, 1) ? 5'($urandom) : 5'd0;
        c  = $urandom_range(0, 1) ? 5'($urandom) : 5'd0;
        im = $urandom_range(0, 1) ? 16'($urandom) : 16'd0;
        if (ty == 2'd2 && $urandom_range(0, 1) == 1) d = im[4:0];
    endtask

    // Records the expected entry when the bundle currently on the inputs is accepted.
    task automatic note_push();
        if (in_valid && in_ready) begin
            q_s.push_back({model_err(1, ty, s2, d, c, im), model_word(ty, op, s1, s2, d, c, im)});
            q_n.push_back({model_err(0, ty, s2, d, c, im), model_word(ty, op, s1, s2, d, c, im)});
        end
    endtask

    task automatic clear_model();
        q_s.delete();
        q_n.delete();
        n_pop = 0; n_err_s = 0; n_err_n = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_inst !== 32'h0) $display("FAIL reset_out_inst got %h want 0", out_inst); else n_pass++;
        n_total++; if (out_err !== 1'b0) $display("FAIL reset_out_err got %b want 0", out_err); else n_pass++;
        n_total++; if (inst_cnt !== 16'h0 || err_cnt !== 16'h0)
            $display("FAIL reset_counters got %h/%h want 0/0", inst_cnt, err_cnt); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
        clear_model();
    endtask

    typedef struct {
        logic [1:0] t; logic [3:0] o; logic [4:0] a, b, de, co; logic [15:0] i;
        logic [31:0] word; logic err_s; logic err_n;
    } vec_t;

    task automatic test_directed();
        vec_t v[4];
        int es = 0, en = 0;
        v[0] = '{2'd1, 4'd3, 5'd2, 5'd7, 5'd0, 5'd0, 16'h0000, 32'h0000_388D, 1'b0, 1'b0};
        v[1] = '{2'd2, 4'd1, 5'd4, 5'd0, 5'd21, 5'd0, 16'h1235, 32'h1235_0106, 1'b0, 1'b0};
        v[2] = '{2'd2, 4'd1, 5'd4, 5'd0, 5'd21, 5'd0, 16'h1234, 32'h1235_0106, 1'b1, 1'b1};
        v[3] = '{2'd3, 4'd0, 5'd0, 5'd1, 5'd0, 5'd3, 16'hFFFF, 32'hFFFF_1803, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ty = v[k].t; op = v[k].o; s1 = v[k].a; s2 = v[k].b; d = v[k].de; c = v[k].co; im = v[k].i;
            in_valid = 1'b1; out_ready = 1'b0;
            #1;
            n_total++; if (out_valid !== 1'b0) $display("FAIL dir%0d_same_cycle out_valid got %b want 0", k, out_valid); else n_pass++;
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            n_total++; if (out_valid !== 1'b1 || out_inst !== v[k].word)
                $display("FAIL dir%0d_word got %b/%h want 1/%h", k, out_valid, out_inst, v[k].word); else n_pass++;
            n_total++; if (out_err !== v[k].err_s) $display("FAIL dir%0d_err_strict got %b want %b", k, out_err, v[k].err_s); else n_pass++;
            n_total++; if (out_err2 !== v[k].err_n) $display("FAIL dir%0d_err_loose got %b want %b", k, out_err2, v[k].err_n); else n_pass++;
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            es += int'(v[k].err_s);
            en += int'(v[k].err_n);
            #1;
            n_total++; if (inst_cnt !== 16'(k + 1) || err_cnt !== 16'(es))
                $display("FAIL dir%0d_counters got %0d/%0d want %0d/%0d", k, inst_cnt, err_cnt, k + 1, es); else n_pass++;
            n_total++; if (err_cnt2 !== 4'(en)) $display("FAIL dir%0d_err_cnt_loose got %0d want %0d", k, err_cnt2, en); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int pushed = 0, popped = 0, cyc = 0;
        logic [32:0] e;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rand_fields();
            in_valid = 1'b1;
            #1;
            if (k == 4) begin
                n_total++; if (in_ready !== 1'b0) $display("FAIL bp_full_in_ready got %b want 0", in_ready); else n_pass++;
            end
            if (k > 0) begin
                n_total++; if (out_inst !== q_s[0][31:0]) $display("FAIL bp_head_stable got %h want %h", out_inst, q_s[0][31:0]); else n_pass++;
            end
            if (in_ready) pushed++;
            note_push();
        end
        // The fifth bundle stays on the inputs until the FIFO makes room.
        while ((pushed < 5 || q_s.size() != 0) && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (pushed == 5) in_valid = 1'b0;
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                e = q_s.pop_front();
                void'(q_n.pop_front());
                popped++;
                n_total++; if ({out_err, out_inst} !== e)
                    $display("FAIL bp_order%0d got %h want %h", popped, {out_err, out_inst}, e); else n_pass++;
            end
            if (in_valid && in_ready) pushed++;
            note_push();
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        n_total++; if (popped !== 5) $display("FAIL bp_count got %0d want 5", popped); else n_pass++;
    endtask

    task automatic test_streaming();
        logic [32:0] e;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            rand_fields();
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            n_total++; if (in_ready !== 1'b1) $display("FAIL stream%0d_in_ready got %b want 1", k, in_ready); else n_pass++;
            if (k > 0) begin
                e = q_s.pop_front();
                void'(q_n.pop_front());
                n_total++; if (out_valid !== 1'b1 || {out_err, out_inst} !== e)
                    $display("FAIL stream%0d_word got %b/%h want 1/%h", k, out_valid, {out_err, out_inst}, e); else n_pass++;
            end
            note_push();
        end
        @(negedge clk);
        in_valid = 1'b0;
        void'(q_s.pop_front());
        void'(q_n.pop_front());
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL stream_drained got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rand_fields();
            in_valid = 1'b1; out_ready = (k % 2 == 0);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0 || out_valid2 !== 1'b0)
            $display("FAIL areset_out_valid got %b/%b want 0/0", out_valid, out_valid2); else n_pass++;
        n_total++; if (inst_cnt !== 16'h0 || err_cnt !== 16'h0 || inst_cnt2 !== 4'h0 || err_cnt2 !== 4'h0)
            $display("FAIL areset_counters got %h/%h/%h/%h want 0", inst_cnt, err_cnt, inst_cnt2, err_cnt2); else n_pass++;
        n_total++; if (out_inst !== 32'h0 || out_err !== 1'b0)
            $display("FAIL areset_out_inst got %h/%b want 0/0", out_inst, out_err); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        #1;
        n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL areset_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); else n_pass++;
        clear_model();
    endtask

    task automatic test_random();
        int cyc = 0;
        logic [32:0] es, en;
        while (n_pop < 10000 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            rand_fields();
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            n_total++; if (inst_cnt !== 16'(n_pop) || err_cnt !== 16'(n_err_s))
                $display("FAIL rnd_cnt got %0d/%0d want %0d/%0d", inst_cnt, err_cnt, 16'(n_pop), 16'(n_err_s)); else n_pass++;
            n_total++; if (inst_cnt2 !== 4'(n_pop) || err_cnt2 !== 4'(n_err_n))
                $display("FAIL rnd_cnt_wrap got %0d/%0d want %0d/%0d", inst_cnt2, err_cnt2, 4'(n_pop), 4'(n_err_n)); else n_pass++;
            n_total++; if (out_valid !== (q_s.size() != 0))
                $display("FAIL rnd_out_valid got %b want %b", out_valid, q_s.size() != 0); else n_pass++;
            if (out_valid && out_ready && q_s.size() != 0) begin
                es = q_s.pop_front();
                en = q_n.pop_front();
                n_pop++;
                n_err_s += int'(es[32]);
                n_err_n += int'(en[32]);
                n_total++; if ({out_err, out_inst} !== es)
                    $display("FAIL rnd_word_strict got %h want %h", {out_err, out_inst}, es); else n_pass++;
                n_total++; if ({out_err2, out_inst2} !== en)
                    $display("FAIL rnd_word_loose got %h want %h", {out_err2, out_inst2}, en); else n_pass++;
            end
            note_push();
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_total++; if (n_pop < 10000) $display("FAIL rnd_timeout got %0d words want 10000", n_pop); else n_pass++;
        n_total++; if (inst_cnt2 !== 4'(n_pop) || inst_cnt !== 16'(n_pop))
            $display("FAIL rnd_final_cnt got %0d/%0d want %0d", inst_cnt, inst_cnt2, n_pop); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_streaming();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
